// File: rtl/ibex_pkg.sv
// BIST engine shared types: FSM states, APB register offsets and per-width Galois polynomials.
// Pure declarations; no timing or flow control of its own.
package ibex_pkg;

    typedef enum logic [1:0] {
        BIST_IDLE  = 2'd0,
        BIST_RUN   = 2'd1,
        BIST_DRAIN = 2'd2,
        BIST_CMP   = 2'd3
    } bist_state_e;

    localparam logic [4:0] BIST_CTRL_OFFSET   = 5'h00;
    localparam logic [4:0] BIST_STATUS_OFFSET = 5'h04;
    localparam logic [4:0] BIST_SEED_OFFSET   = 5'h08;
    localparam logic [4:0] BIST_GOLDEN_OFFSET = 5'h0C;
    localparam logic [4:0] BIST_SIG_OFFSET    = 5'h10;
    localparam logic [4:0] BIST_PATCNT_OFFSET = 5'h14;

    // Right-shift Galois tap masks (maximal-length polynomials).
    localparam logic [15:0] BIST_POLY_16 = 16'hB400;
    localparam logic [31:0] BIST_POLY_32 = 32'h8020_0003;
    localparam logic [63:0] BIST_POLY_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] bist_poly(int unsigned width);
        case (width)
            16:      return {48'h0, BIST_POLY_16};
            32:      return {32'h0, BIST_POLY_32};
            64:      return BIST_POLY_64;
            default: return (64'h1 << (width - 1)) | 64'h1;
        endcase
    endfunction

endpackage

// File: rtl/ibex_bist_lfsr.sv
// Galois LFSR / MISR register with load, step and parallel xor-in.
// New state one cycle after load_i or step_i; load_i has priority.
module ibex_bist_lfsr #(
    parameter int unsigned      Width = 32,
    parameter logic [Width-1:0] Poly  = {Width{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             step_i,
    input  logic [Width-1:0] xor_i,
    output logic [Width-1:0] state_o
);

    logic [Width-1:0] state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else if (load_i) begin
            state_q <= load_val_i;
        end else if (step_i) begin
            state_q <= ((state_q >> 1) ^ (state_q[0] ? Poly : '0)) ^ xor_i;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ibex_bist_engine.sv
// Logic BIST engine: sweeps LFSR operands over a datapath, compresses results into a MISR, compares to GOLDEN.
// APB is zero-wait (pready_o tied high); results are sampled ResultLatency cycles after their operands.
module ibex_bist_engine
    import ibex_pkg::*;
#(
    parameter int unsigned  DataWidth     = 32,
    parameter int unsigned  NumPatterns   = 256,
    parameter int unsigned  NumOps        = 4,
    parameter int unsigned  ResultLatency = 0,
    localparam int unsigned OpW           = (NumOps > 1) ? $clog2(NumOps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_sleep_i,
    input  logic                 sim_fault_inject_i,
    input  logic [31:0]          paddr_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [31:0]          pwdata_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 bist_active_o,
    output logic [OpW-1:0]       bist_op_idx_o,
    output logic [DataWidth-1:0] bist_operand_a_o,
    output logic [DataWidth-1:0] bist_operand_b_o,
    input  logic [DataWidth-1:0] bist_result_i,
    output logic                 bist_error_irq_o
);

    localparam int unsigned         PatW      = $clog2(NumPatterns);
    localparam int unsigned         Half      = DataWidth / 2;
    localparam logic [DataWidth-1:0] Poly     = DataWidth'(bist_poly(DataWidth));
    localparam logic [2:0]          LatSel    = 3'(ResultLatency);
    localparam logic [1:0]          DrainLast = 2'(ResultLatency - 1);

    bist_state_e         state_q;
    logic                active_q, auto_run_q, sleep_q, irq_q;
    logic                ctrl_irq_en_q, ctrl_auto_q;
    logic                done_q, fail_q, abort_q;
    logic [DataWidth-1:0] seed_q, golden_q, sig_q;
    logic [31:0]         patcnt_q;
    logic [PatW-1:0]     pat_cnt_q;
    logic [OpW-1:0]      op_cnt_q;
    logic [1:0]          drain_cnt_q;
    logic [3:0]          lat_pipe_q;

    logic [4:0]          reg_addr;
    logic [4:0]          issue_hist;
    logic                apb_wr, ctrl_wr, status_wr, busy, in_run;
    logic                start_run, abort_run, last_pattern, compress_en;
    logic                irq_en_d, done_d, fail_d, abort_d;
    logic [DataWidth-1:0] lfsr_state, misr_state, seed_load;
    logic                unused_addr;

    assign reg_addr    = paddr_i[4:0];
    assign unused_addr = ^paddr_i[31:5];
    // issue_hist[n] is high when the result of operands issued n cycles ago is valid now
    assign issue_hist  = {lat_pipe_q, in_run};
    assign compress_en = issue_hist[LatSel];
    assign seed_load   = (seed_q == '0) ? DataWidth'(1) : seed_q;

    always_comb begin
        apb_wr       = psel_i & penable_i & pwrite_i;
        ctrl_wr      = apb_wr && (reg_addr == BIST_CTRL_OFFSET);
        status_wr    = apb_wr && (reg_addr == BIST_STATUS_OFFSET);
        busy         = (state_q != BIST_IDLE);
        in_run       = (state_q == BIST_RUN);
        start_run    = !busy && ((ctrl_wr && pwdata_i[0]) ||
                                 (ctrl_auto_q && core_sleep_i && !sleep_q));
        abort_run    = auto_run_q && !core_sleep_i && sleep_q &&
                       (in_run || (state_q == BIST_DRAIN));
        last_pattern = in_run && (pat_cnt_q == PatW'(NumPatterns - 1)) &&
                       (op_cnt_q == OpW'(NumOps - 1));
        irq_en_d     = ctrl_wr ? pwdata_i[2] : ctrl_irq_en_q;
        done_d       = done_q  & ~(status_wr & pwdata_i[1]);
        fail_d       = fail_q  & ~(status_wr & pwdata_i[2]);
        abort_d      = abort_q & ~(status_wr & pwdata_i[3]);
        if (start_run) begin
            done_d  = 1'b0;
            fail_d  = 1'b0;
            abort_d = 1'b0;
        end
        // Hardware set is applied last so it wins over a same-cycle W1C
        if (state_q == BIST_CMP) begin
            done_d = 1'b1;
            if (misr_state != golden_q) fail_d = 1'b1;
        end
        if (abort_run) begin
            abort_d = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= BIST_IDLE;
            active_q      <= 1'b0;
            auto_run_q    <= 1'b0;
            sleep_q       <= 1'b0;
            irq_q         <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            ctrl_auto_q   <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            abort_q       <= 1'b0;
            seed_q        <= '0;
            golden_q      <= '0;
            sig_q         <= '0;
            patcnt_q      <= '0;
            pat_cnt_q     <= '0;
            op_cnt_q      <= '0;
            drain_cnt_q   <= '0;
            lat_pipe_q    <= '0;
        end else begin
            sleep_q    <= core_sleep_i;
            done_q     <= done_d;
            fail_q     <= fail_d;
            abort_q    <= abort_d;
            irq_q      <= fail_d & irq_en_d;
            lat_pipe_q <= (start_run || abort_run) ? 4'b0 : {lat_pipe_q[2:0], in_run};
            if (ctrl_wr) begin
                ctrl_irq_en_q <= pwdata_i[2];
                ctrl_auto_q   <= pwdata_i[1];
            end
            if (apb_wr && !busy && (reg_addr == BIST_SEED_OFFSET))   seed_q   <= DataWidth'(pwdata_i);
            if (apb_wr && !busy && (reg_addr == BIST_GOLDEN_OFFSET)) golden_q <= DataWidth'(pwdata_i);
            unique case (state_q)
                BIST_IDLE: begin
                    if (start_run) begin
                        state_q    <= BIST_RUN;
                        active_q   <= 1'b1;
                        auto_run_q <= !(ctrl_wr && pwdata_i[0]);
                        pat_cnt_q  <= '0;
                        op_cnt_q   <= '0;
                        patcnt_q   <= '0;
                    end
                end
                BIST_RUN: begin
                    if (abort_run) begin
                        state_q  <= BIST_IDLE;
                        active_q <= 1'b0;
                    end else begin
                        pat_cnt_q <= pat_cnt_q + 1'b1;
                        patcnt_q  <= patcnt_q + 32'd1;
                        if (pat_cnt_q == PatW'(NumPatterns - 1)) op_cnt_q <= op_cnt_q + 1'b1;
                        if (last_pattern) begin
                            if (ResultLatency == 0) begin
                                state_q  <= BIST_CMP;
                                active_q <= 1'b0;
                            end else begin
                                state_q     <= BIST_DRAIN;
                                drain_cnt_q <= '0;
                            end
                        end
                    end
                end
                BIST_DRAIN: begin
                    if (abort_run) begin
                        state_q  <= BIST_IDLE;
                        active_q <= 1'b0;
                    end else if (drain_cnt_q == DrainLast) begin
                        state_q  <= BIST_CMP;
                        active_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                BIST_CMP: begin
                    sig_q   <= misr_state;
                    state_q <= BIST_IDLE;
                end
                default: begin
                    state_q  <= BIST_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    ibex_bist_lfsr #(.Width(DataWidth), .Poly(Poly)) u_gen (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (start_run),
        .load_val_i (seed_load),
        .step_i     (in_run),
        .xor_i      ('0),
        .state_o    (lfsr_state)
    );

    ibex_bist_lfsr #(.Width(DataWidth), .Poly(Poly)) u_misr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (start_run),
        .load_val_i ('0),
        .step_i     (compress_en),
        .xor_i      (bist_result_i ^ DataWidth'(sim_fault_inject_i)),
        .state_o    (misr_state)
    );

    always_comb begin
        prdata_o = '0;
        if (psel_i && !pwrite_i) begin
            case (reg_addr)
                BIST_CTRL_OFFSET:   prdata_o = {29'd0, ctrl_irq_en_q, ctrl_auto_q, 1'b0};
                BIST_STATUS_OFFSET: prdata_o = {28'd0, abort_q, fail_q, done_q, busy};
                BIST_SEED_OFFSET:   prdata_o = 32'(seed_q);
                BIST_GOLDEN_OFFSET: prdata_o = 32'(golden_q);
                BIST_SIG_OFFSET:    prdata_o = 32'(sig_q);
                BIST_PATCNT_OFFSET: prdata_o = patcnt_q;
                default:            prdata_o = '0;
            endcase
        end
    end

    assign pready_o         = 1'b1;
    assign bist_active_o    = active_q;
    assign bist_error_irq_o = irq_q;
    assign bist_op_idx_o    = in_run ? op_cnt_q : '0;
    assign bist_operand_a_o = in_run ? lfsr_state : '0;
    assign bist_operand_b_o = in_run ? ((lfsr_state << Half) | (lfsr_state >> (DataWidth - Half))) : '0;

endmodule
